// File: rtl/sd_host_regfile.sv
// Address-decoded SD host register bank: host request/response port, RW1C interrupt status,
// hardware update ports and masked irq. Optional macro: SD_HOST_REGS_SOFT_RESET_EN (0x2C soft reset).
module sd_host_regfile #(
   parameter int ADDR_W      = 8,
   parameter int ADMA_ADDR_W = 64,
   parameter int BLK_CNT_W   = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   req_valid,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [31:0]            req_wdata,
   input  logic [3:0]             req_be,
   output logic                   resp_valid,
   output logic [31:0]            resp_rdata,
   output logic                   resp_err,
   input  logic [31:0]            hw_psr,
   input  logic [15:0]            hw_nisr_set,
   input  logic [15:0]            hw_eisr_set,
   input  logic                   hw_resp_we,
   input  logic [127:0]           hw_resp_data,
   input  logic                   hw_blk_cnt_dec,
   output logic [15:0]            blk_size,
   output logic [BLK_CNT_W-1:0]   blk_cnt,
   output logic [31:0]            argument,
   output logic [15:0]            xfer_mode,
   output logic [15:0]            command,
   output logic                   cmd_start,
   output logic [7:0]             bgcr,
   output logic [ADMA_ADDR_W-1:0] adma_addr,
   output logic                   irq
);

   localparam bit HAS_HI = (ADMA_ADDR_W == 64);
   localparam logic [ADDR_W-1:0] OFF_BLK     = ADDR_W'('h04);
   localparam logic [ADDR_W-1:0] OFF_ARG     = ADDR_W'('h08);
   localparam logic [ADDR_W-1:0] OFF_CMD     = ADDR_W'('h0C);
   localparam logic [ADDR_W-1:0] OFF_RSP0    = ADDR_W'('h10);
   localparam logic [ADDR_W-1:0] OFF_RSP1    = ADDR_W'('h14);
   localparam logic [ADDR_W-1:0] OFF_RSP2    = ADDR_W'('h18);
   localparam logic [ADDR_W-1:0] OFF_RSP3    = ADDR_W'('h1C);
   localparam logic [ADDR_W-1:0] OFF_PSR     = ADDR_W'('h24);
   localparam logic [ADDR_W-1:0] OFF_BGCR    = ADDR_W'('h28);
   localparam logic [ADDR_W-1:0] OFF_SRST    = ADDR_W'('h2C);
   localparam logic [ADDR_W-1:0] OFF_ISR     = ADDR_W'('h30);
   localparam logic [ADDR_W-1:0] OFF_STAT_EN = ADDR_W'('h34);
   localparam logic [ADDR_W-1:0] OFF_SIG_EN  = ADDR_W'('h38);
   localparam logic [ADDR_W-1:0] OFF_ADMA_LO = ADDR_W'('h58);
   localparam logic [ADDR_W-1:0] OFF_ADMA_HI = ADDR_W'('h5C);

   logic [14:0]          nisr;
   logic [15:0]          eisr;
   logic [31:0]          stat_en;
   logic [31:0]          sig_en;
   logic [31:0]          adma_lo;
   logic [31:0]          adma_hi;
   logic [31:0]          resp_word [4];

   logic [ADDR_W-1:0]    off;
   logic                 wr;
   logic                 hit;
   logic [31:0]          rd_mux;
   logic [15:0]          blk_cnt_ext;
   logic [15:0]          nisr_full;
   logic [31:0]          blk_wr;
   logic [BLK_CNT_W-1:0] blk_cnt_next;
   logic [14:0]          nisr_next;
   logic [15:0]          eisr_next;
   logic [31:0]          w1c_mask;
   logic                 irq_next;
   logic                 srst_all;
   logic                 srst_cmd;
   logic                 srst_dat;
   logic                 unused_bits;

   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

   assign off         = {req_addr[ADDR_W-1:2], 2'b00};
   assign wr          = req_valid & req_write;
   assign blk_cnt_ext = 16'(blk_cnt);
   assign nisr_full   = {|eisr, nisr};
   assign adma_addr   = ADMA_ADDR_W'({adma_hi, adma_lo});
   assign unused_bits = ^{req_addr[1:0], hw_nisr_set[15]};

`ifdef SD_HOST_REGS_SOFT_RESET_EN
   logic w_srst;
   assign w_srst   = wr && (off == OFF_SRST) && req_be[3];
   assign srst_all = w_srst & req_wdata[24];
   assign srst_cmd = w_srst & req_wdata[25];
   assign srst_dat = w_srst & req_wdata[26];
`else
   assign srst_all = 1'b0;
   assign srst_cmd = 1'b0;
   assign srst_dat = 1'b0;
`endif

   // Read decode sees register values from before this edge's updates.
   always_comb begin
      rd_mux = '0;
      hit    = 1'b0;
      case (off)
         OFF_BLK:     begin hit = 1'b1; rd_mux = {blk_cnt_ext, blk_size}; end
         OFF_ARG:     begin hit = 1'b1; rd_mux = argument; end
         OFF_CMD:     begin hit = 1'b1; rd_mux = {command, xfer_mode}; end
         OFF_RSP0:    begin hit = 1'b1; rd_mux = resp_word[0]; end
         OFF_RSP1:    begin hit = 1'b1; rd_mux = resp_word[1]; end
         OFF_RSP2:    begin hit = 1'b1; rd_mux = resp_word[2]; end
         OFF_RSP3:    begin hit = 1'b1; rd_mux = resp_word[3]; end
         OFF_PSR:     begin hit = 1'b1; rd_mux = hw_psr; end
         OFF_BGCR:    begin hit = 1'b1; rd_mux = {8'h00, bgcr, 16'h0000}; end
`ifdef SD_HOST_REGS_SOFT_RESET_EN
         OFF_SRST:    hit = 1'b1;
`endif
         OFF_ISR:     begin hit = 1'b1; rd_mux = {eisr, nisr_full}; end
         OFF_STAT_EN: begin hit = 1'b1; rd_mux = stat_en; end
         OFF_SIG_EN:  begin hit = 1'b1; rd_mux = sig_en; end
         OFF_ADMA_LO: begin hit = 1'b1; rd_mux = adma_lo; end
         OFF_ADMA_HI: if (HAS_HI) begin hit = 1'b1; rd_mux = adma_hi; end
         default:     ;
      endcase
   end

   // Software write to block count beats the hardware decrement; set beats RW1C.
   always_comb begin
      blk_wr   = be_merge({blk_cnt_ext, blk_size}, req_wdata, req_be);
      w1c_mask = '0;
      if (wr && off == OFF_ISR) w1c_mask = be_merge(32'h0, req_wdata, req_be);
      if (wr && off == OFF_BLK && (req_be[3] || req_be[2]))
         blk_cnt_next = blk_wr[16 +: BLK_CNT_W];
      else if (hw_blk_cnt_dec && blk_cnt != '0)
         blk_cnt_next = blk_cnt - BLK_CNT_W'(1);
      else
         blk_cnt_next = blk_cnt;
      nisr_next = (nisr & ~w1c_mask[14:0]) | (hw_nisr_set[14:0] & stat_en[14:0]);
      eisr_next = (eisr & ~w1c_mask[31:16]) | (hw_eisr_set & stat_en[31:16]);
      irq_next  = |((nisr_full & sig_en[15:0]) | (eisr & sig_en[31:16]));
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         cmd_start  <= 1'b0;
         irq        <= 1'b0;
         blk_size   <= '0;
         blk_cnt    <= '0;
         argument   <= '0;
         xfer_mode  <= '0;
         command    <= '0;
         bgcr       <= '0;
         nisr       <= '0;
         eisr       <= '0;
         stat_en    <= '0;
         sig_en     <= '0;
         adma_lo    <= '0;
         adma_hi    <= '0;
         for (int i = 0; i < 4; i++) resp_word[i] <= '0;
      end else begin
         resp_valid <= req_valid;
         resp_rdata <= (req_valid && !req_write) ? rd_mux : 32'h0;
         resp_err   <= req_valid && !hit;
         cmd_start  <= wr && (off == OFF_CMD) && req_be[3];
         irq        <= irq_next;
         blk_cnt    <= blk_cnt_next;
         nisr       <= nisr_next;
         eisr       <= eisr_next;
         if (wr && off == OFF_BLK) blk_size <= blk_wr[15:0];
         if (wr && off == OFF_ARG) argument <= be_merge(argument, req_wdata, req_be);
         if (wr && off == OFF_CMD) begin
            {command, xfer_mode} <= be_merge({command, xfer_mode}, req_wdata, req_be);
         end
         if (wr && off == OFF_BGCR && req_be[2]) bgcr <= req_wdata[23:16];
         if (wr && off == OFF_STAT_EN) stat_en <= be_merge(stat_en, req_wdata, req_be);
         if (wr && off == OFF_SIG_EN) sig_en <= be_merge(sig_en, req_wdata, req_be);
         if (wr && off == OFF_ADMA_LO) adma_lo <= be_merge(adma_lo, req_wdata, req_be);
         if (HAS_HI && wr && off == OFF_ADMA_HI) adma_hi <= be_merge(adma_hi, req_wdata, req_be);
         if (hw_resp_we) begin
            for (int i = 0; i < 4; i++) resp_word[i] <= hw_resp_data[32*i +: 32];
         end
         // Soft resets override this edge's updates but leave the host response intact.
         if (srst_cmd || srst_all) begin
            command  <= '0;
            argument <= '0;
            for (int i = 0; i < 4; i++) resp_word[i] <= '0;
         end
         if (srst_dat || srst_all) begin
            blk_cnt   <= '0;
            xfer_mode <= '0;
            bgcr      <= '0;
         end
         if (srst_all) begin
            cmd_start <= 1'b0;
            irq       <= 1'b0;
            blk_size  <= '0;
            nisr      <= '0;
            eisr      <= '0;
            stat_en   <= '0;
            sig_en    <= '0;
            adma_lo   <= '0;
            adma_hi   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sd_host_regfile.sv
// Directed self-checking bench for sd_host_regfile; honours SD_HOST_REGS_SOFT_RESET_EN if defined.
module tb_sd_host_regfile;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_write;
   logic [7:0]   req_addr;
   logic [31:0]  req_wdata;
   logic [3:0]   req_be;
   logic         resp_valid, resp_err;
   logic [31:0]  resp_rdata;
   logic [31:0]  hw_psr;
   logic [15:0]  hw_nisr_set, hw_eisr_set;
   logic         hw_resp_we, hw_blk_cnt_dec;
   logic [127:0] hw_resp_data;
   logic [15:0]  blk_size, blk_cnt, xfer_mode, command;
   logic [31:0]  argument;
   logic         cmd_start, irq;
   logic [7:0]   bgcr;
   logic [63:0]  adma_addr;

   logic         got_valid, got_err;
   logic [31:0]  got_rdata;
   int           check_count = 0;
   int           error_count = 0;

   sd_host_regfile dut (
      .CLK(clk), .RESET(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .hw_psr(hw_psr), .hw_nisr_set(hw_nisr_set), .hw_eisr_set(hw_eisr_set),
      .hw_resp_we(hw_resp_we), .hw_resp_data(hw_resp_data), .hw_blk_cnt_dec(hw_blk_cnt_dec),
      .blk_size(blk_size), .blk_cnt(blk_cnt), .argument(argument), .xfer_mode(xfer_mode),
      .command(command), .cmd_start(cmd_start), .bgcr(bgcr), .adma_addr(adma_addr), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_count++;
      assert (obs === exp) else begin
         error_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request cycle; returns #1 after the response edge with the response captured.
   task automatic apply_stimulus(input logic wr, input logic [7:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; req_be = '0;
      got_valid = resp_valid; got_rdata = resp_rdata; got_err = resp_err;
      check_output("resp_valid", 64'(got_valid), 64'd1);
   endtask

   task automatic idle_cycle;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
      hw_psr = 32'h1234_5678; hw_nisr_set = 0; hw_eisr_set = 0; hw_resp_we = 0;
      hw_resp_data = 0; hw_blk_cnt_dec = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle_cycle();

      // Reset values and response timing
      apply_stimulus(0, 8'h04, 0, 0);
      check_output("rd04", 64'(got_rdata), 0); check_output("err04", 64'(got_err), 0);
      idle_cycle();
      check_output("resp_valid_drop", 64'(resp_valid), 0);
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("rd30", 64'(got_rdata), 0);
      apply_stimulus(0, 8'h58, 0, 0);
      check_output("rd58", 64'(got_rdata), 0); check_output("err58", 64'(got_err), 0);
      check_output("irq_rst", 64'(irq), 0);

      // Block count load and decrement with no wrap
      apply_stimulus(1, 8'h04, 32'h0003_0200, 4'hF);
      check_output("blk_cnt3", 64'(blk_cnt), 3); check_output("blk_size", 64'(blk_size), 64'h200);
      for (int i = 2; i >= -1; i--) begin
         hw_blk_cnt_dec = 1; idle_cycle(); hw_blk_cnt_dec = 0;
         check_output("blk_dec", 64'(blk_cnt), (i < 0) ? 64'd0 : 64'(i));
      end
      // Byte-lane write of the count beats a same-cycle decrement
      hw_blk_cnt_dec = 1; apply_stimulus(1, 8'h04, 32'h0007_0000, 4'h4); hw_blk_cnt_dec = 0;
      check_output("blk_wr_dec", 64'(blk_cnt), 7); check_output("blk_size_keep", 64'(blk_size), 64'h200);
      hw_blk_cnt_dec = 1; apply_stimulus(1, 8'h04, 32'h0000_0040, 4'h1); hw_blk_cnt_dec = 0;
      check_output("blk_dec_sz_wr", 64'(blk_cnt), 6); check_output("blk_size_b0", 64'(blk_size), 64'h240);

      // Interrupt status capture, irq timing and RW1C
      apply_stimulus(1, 8'h34, 32'hFFFF_FFFF, 4'hF);
      apply_stimulus(1, 8'h38, 32'h0000_0001, 4'hF);
      hw_nisr_set = 16'h0001; idle_cycle(); hw_nisr_set = 0;
      check_output("irq_lag", 64'(irq), 0);
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("nisr_set", 64'(got_rdata), 64'h0000_0001); check_output("irq_on", 64'(irq), 1);
      apply_stimulus(1, 8'h30, 32'h0000_0001, 4'hF);
      idle_cycle();
      check_output("irq_off", 64'(irq), 0);
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("nisr_clr", 64'(got_rdata), 0);

      // Error status, summary bit and set-beats-clear
      hw_eisr_set = 16'h0004; idle_cycle(); hw_eisr_set = 0;
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("eisr_sum", 64'(got_rdata), 64'h0004_8000);
      hw_eisr_set = 16'h0004; apply_stimulus(1, 8'h30, 32'h0004_0000, 4'hF); hw_eisr_set = 0;
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("set_wins", 64'(got_rdata), 64'h0004_8000);
      apply_stimulus(1, 8'h30, 32'h0004_8000, 4'hF);
      apply_stimulus(0, 8'h30, 0, 0);
      check_output("eisr_clr", 64'(got_rdata), 0);

      // Command write, cmd_start pulse, unmapped offset
      apply_stimulus(1, 8'h0C, 32'h1A2B_0011, 4'hC);
      check_output("cmd_start", 64'(cmd_start), 1); check_output("command", 64'(command), 64'h1A2B);
      check_output("xfer_mode", 64'(xfer_mode), 0);
      idle_cycle();
      check_output("cmd_start_off", 64'(cmd_start), 0);
      apply_stimulus(0, 8'h60, 0, 0);
      check_output("rd60", 64'(got_rdata), 0); check_output("err60", 64'(got_err), 1);

      // Read-only offsets, response load and ADMA address
      apply_stimulus(1, 8'h24, 32'hFFFF_FFFF, 4'hF);
      check_output("ro_err", 64'(got_err), 0);
      apply_stimulus(0, 8'h24, 0, 0);
      check_output("psr", 64'(got_rdata), 64'h1234_5678);
      hw_resp_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      hw_resp_we = 1; apply_stimulus(0, 8'h10, 0, 0); hw_resp_we = 0;
      check_output("rsp_old", 64'(got_rdata), 0);
      apply_stimulus(0, 8'h10, 0, 0);
      check_output("rsp0", 64'(got_rdata), 64'h1111_1111);
      apply_stimulus(0, 8'h1C, 0, 0);
      check_output("rsp3", 64'(got_rdata), 64'h4444_4444);
      apply_stimulus(1, 8'h58, 32'h89AB_CDEF, 4'hF);
      apply_stimulus(1, 8'h5C, 32'h0123_4567, 4'hF);
      check_output("adma", adma_addr, 64'h0123_4567_89AB_CDEF);
      apply_stimulus(1, 8'h28, 32'h00A5_0000, 4'h4);
      check_output("bgcr", 64'(bgcr), 64'hA5);

`ifdef SD_HOST_REGS_SOFT_RESET_EN
      apply_stimulus(1, 8'h08, 32'hDEAD_BEEF, 4'hF);
      apply_stimulus(1, 8'h04, 32'h0005_0000, 4'hC);
      apply_stimulus(1, 8'h2C, 32'h0200_0000, 4'h8);
      check_output("srst_arg", 64'(argument), 0); check_output("srst_blk", 64'(blk_cnt), 5);
      check_output("srst_cmd", 64'(command), 0);
      apply_stimulus(0, 8'h2C, 0, 0);
      check_output("rd2c", 64'(got_rdata), 0); check_output("err2c", 64'(got_err), 0);
      apply_stimulus(0, 8'h10, 0, 0);
      check_output("srst_rsp", 64'(got_rdata), 0);
      apply_stimulus(1, 8'h2C, 32'h0400_0000, 4'h8);
      check_output("srst_dat", 64'(blk_cnt), 0); check_output("srst_bgcr", 64'(bgcr), 0);
      check_output("dat_keep_sz", 64'(blk_size), 64'h240);
      apply_stimulus(1, 8'h2C, 32'h0100_0000, 4'h8);
      check_output("srst_all_sz", 64'(blk_size), 0); check_output("srst_all_adma", adma_addr, 0);
`else
      apply_stimulus(0, 8'h2C, 0, 0);
      check_output("err2c", 64'(got_err), 1);
`endif

      // Asynchronous reset drops a pending response
      req_valid = 1; req_write = 0; req_addr = 8'h08;
      @(posedge clk); #1; req_valid = 0;
      check_output("pend_valid", 64'(resp_valid), 1);
      rst_n = 1'b0; #1;
      check_output("async_drop", 64'(resp_valid), 0);
      check_output("async_blk", 64'(blk_size), 0);
      #3 rst_n = 1'b1;
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/sd_host_regfile.md
Name: sd_host_regfile

Overview:
Parametrised, address-decoded SD host register bank. It replaces the discrete fixed-width register instances at the SD host top level. It provides a single host-side request/response port using the SD Host Controller offsets, write-1-to-clear interrupt status, hardware set/update ports, and a masked interrupt output. It sits between the system bus and the CMD/DAT/ADMA engines.

Parameters:
ADDR_W, 8, byte-address width of the host port; offsets are the low ADDR_W bits.
ADMA_ADDR_W, 64, ADMA system address width; legal values are 32 or 64. At 32, offset 0x5C is unmapped.
BLK_CNT_W, 16, block count register width (1..16); upper bits read 0.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-low reset; 0 clears all state immediately.
req_valid  in  1  host access request, single-cycle pulse.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address; bits [1:0] are ignored (32-bit word access).
req_wdata  in  32  write data.
req_be  in  4  byte enables for writes.
resp_valid  out  1  pulses exactly 1 cycle after req_valid.
resp_rdata  out  32  read data, valid with resp_valid; 0 for writes.
resp_err  out  1  asserted with resp_valid on an unmapped offset.
hw_psr  in  32  Present State value, read-only mirror.
hw_nisr_set  in  16  per-bit set pulses for Normal Interrupt Status (bit 15 ignored).
hw_eisr_set  in  16  per-bit set pulses for Error Interrupt Status.
hw_resp_we  in  1  loads the response registers.
hw_resp_data  in  128  command response.
hw_blk_cnt_dec  in  1  decrements block count by 1.
blk_size  out  16  Block Size register.
blk_cnt  out  BLK_CNT_W  Block Count register.
argument  out  32  Argument register.
xfer_mode  out  16  Transfer Mode register.
command  out  16  Command register.
cmd_start  out  1  1-cycle pulse, registered, on any write with req_be[3]=1 to 0x0C.
bgcr  out  8  Block Gap Control register.
adma_addr  out  ADMA_ADDR_W  ADMA System Address register.
irq  out  1  masked interrupt request.

Behaviour:
- Register map (word offset; each field is byte-lane aligned):
  - 0x04: Block Size [15:0], RW; Block Count [31:16], RW.
  - 0x08: Argument, RW.
  - 0x0C: Transfer Mode [15:0], RW; Command [31:16], RW.
  - 0x10–0x1C: Response words 0–3, RO.
  - 0x24: Present State, RO.
  - 0x28: Block Gap Control [23:16], RW; other bits read 0.
  - 0x30: NISR [15:0], RW1C; EISR [31:16], RW1C.
  - 0x34: NISR/EISR status enable, RW.
  - 0x38: NISR/EISR signal enable, RW.
  - 0x58 / 0x5C: ADMA address low / high, RW.
- Any other offset: read returns 0; write has no effect; resp_err=1.
- Reset values: all registers 0; resp_valid, resp_rdata, resp_err, cmd_start and irq are 0.
- Reset is asynchronous. Asserting RESET mid-transaction drops any pending resp_valid.
- Read latency is 1 cycle: resp_rdata is registered from the value before any same-cycle update. Back-to-back requests on every cycle are supported.
- Writes honour req_be per byte and take effect at the request edge.
- Write to a RO offset: no effect, resp_err=0.
- Status bit capture: a status bit latches when hw set=1 and its status-enable bit=1. Bits with status-enable=0 stay 0.
- NISR bit 15 (error summary) is combinational: |EISR. It is RO; writes to it are ignored.
- RW1C: writing 1 clears the bit; writing 0 leaves it unchanged.
- Same cycle hw set and RW1C on the same bit: set wins, bit stays 1.
- Block count:
  - hw_blk_cnt_dec at 0 stays 0 (no wrap).
  - Software write and decrement in the same cycle: software value wins.
  - Partial byte write with decrement: written bytes take new data; the decrement is dropped.
- hw_resp_we loads all 4 response words in 1 cycle. Read of a response word in that same cycle returns the old value.
- irq = |((NISR & NSIG_EN) | (EISR & ESIG_EN)), registered, 1-cycle delay from the status change.

Optional Feature:
SD_HOST_REGS_SOFT_RESET_EN:
- When defined: offset 0x2C byte 3 is the Software Reset register. Bit 24 = reset all, bit 25 = reset CMD, bit 26 = reset DAT; the bits are self-clearing.
  - Reset all: synchronously clears every register next cycle, same as RESET except the host port completes the current response.
  - Reset CMD: clears Command, Argument and Response.
  - Reset DAT: clears Block Count, Transfer Mode and BGCR.
  - Reads of 0x2C return 0.
- When not defined: 0x2C is unmapped (resp_err=1).

Test Plan:
1. Reset, then read 0x04, 0x30, 0x58 -> resp_rdata=0, resp_err=0, irq=0; resp_valid exactly 1 cycle after each req_valid.
2. Write 0x04=0x0003_0200 be=0xF; apply 3 hw_blk_cnt_dec pulses, then 1 more -> blk_cnt 3,2,1,0,0; blk_size=0x200.
3. Write 0x34=0xFFFF_FFFF, 0x38=0x0000_0001; pulse hw_nisr_set=0x0001 -> NISR reads 0x0001 and irq=1 one cycle later. Write 0x30=0x1 -> NISR=0, irq=0.
4. Pulse hw_eisr_set=0x0004 -> 0x30 reads 0x0004_8000. Write 0x30=0x0004_0000 in the same cycle as a fresh hw_eisr_set=0x0004 -> bit remains set.
5. Write 0x0C=0x1A2B_0011 be=0xC -> cmd_start pulses once, command=0x1A2B, xfer_mode=0. Read 0x60 -> rdata=0, resp_err=1.
6. With SD_HOST_REGS_SOFT_RESET_EN: load Argument=0xDEADBEEF and BCR=5; write 0x2C=0x0200_0000 -> argument=0, blk_cnt=5, and 0x2C reads 0.
